// File: rtl/ofdm_sched_pkg.sv
// ofdm_sched_pkg: state encodings and symbol geometry shared by the OFDM symbol scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ofdm_sched_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_COLLECT,
    F_IFFT,
    F_READY
  } front_state_e;

  typedef enum logic {
    B_IDLE,
    B_SER
  } back_state_e;

  // Nibbles fetched from the serializer for one OFDM symbol's worth of QAM data.
  localparam int NIBBLES_PER_SYM = 8;

endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog: counts consecutive cycles spent waiting on an awaited stage done.
// Latency: expire_o is combinational from the count; the scheduler registers the result.
// Backpressure: none; kick_i restarts the count, a deasserted active_i clears it.
module sched_watchdog #(
  parameter int WDOG_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Fires in the WDOG_CYCLES-th consecutive waiting cycle without a kick.
  assign expire_o = active_i && !kick_i && (cnt_q == CW'(WDOG_CYCLES - 1));

  // Wait counter: restarts at the beginning of every wait, holds once expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!active_i || kick_i) begin
      cnt_q <= '0;
    end else if (!expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// ofdm_symbol_scheduler: sequences S2P collection, IFFT wait and CP-insert handoff per OFDM symbol.
// Latency: go -> S2P/S2P_REG start 1 cycle; S2P_REG_done -> CPI_start IFFT_LAT+1 cycles when CPI is free.
// Backpressure: front parks in F_READY while CPI serializes; stage watchdog only with SCHED_WATCHDOG_EN.
module ofdm_symbol_scheduler
  import ofdm_sched_pkg::*;
#(
  parameter int NSYM_W      = 8,
  parameter int IFFT_LAT    = 2,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [NSYM_W-1:0] num_symbols,
  input  logic              S2P_done,
  input  logic              S2P_REG_done,
  input  logic              CPI_done,
  output logic              S2P_start,
  output logic              S2P_REG_start,
  output logic              CPI_start,
  output logic              CPIdataValid,
  output logic              busy,
  output logic              frame_done,
  output logic [NSYM_W-1:0] sym_count,
  output logic              timeout
);

  localparam logic [3:0] NIB_MAX   = 4'(NIBBLES_PER_SYM);
  localparam logic [3:0] NIB_LAST  = 4'(NIBBLES_PER_SYM - 1);
  localparam logic [3:0] IFFT_LAST = 4'(IFFT_LAT - 1);

  front_state_e      front_q;
  back_state_e       back_q;
  logic [3:0]        nib_q;
  logic [3:0]        ifft_q;
  logic [NSYM_W-1:0] nsym_q;
  logic [NSYM_W-1:0] sym_q;
  logic              s2p_start_q;
  logic              s2p_reg_start_q;
  logic              cpi_start_q;
  logic              cpi_valid_q;
  logic              busy_q;
  logic              frame_done_q;

  logic go_acc, in_collect, s2p_seen, reg_seen, ifft_end, cpi_seen;
  logic back_free, handoff, more_syms, frame_end, wdog_expire;

  assign go_acc     = go && !busy_q && (num_symbols != '0);
  assign in_collect = (front_q == F_COLLECT);
  assign s2p_seen   = in_collect && S2P_done;
  assign reg_seen   = in_collect && S2P_REG_done;
  assign ifft_end   = (front_q == F_IFFT) && (ifft_q == IFFT_LAST);
  assign cpi_seen   = (back_q == B_SER) && CPI_done;
  // CPI can take a new symbol if idle, or if it finishes the current one this cycle.
  assign back_free  = (back_q == B_IDLE) || cpi_seen;
  // The last IFFT cycle hands off directly; F_READY only holds a symbol while CPI is busy.
  assign handoff    = (ifft_end || (front_q == F_READY)) && back_free;
  assign more_syms  = (sym_q + 1'b1) < nsym_q;
  assign frame_end  = cpi_seen && (front_q == F_IDLE) && busy_q;

`ifdef SCHED_WATCHDOG_EN
  logic wdog_active, wdog_kick, timeout_q;

  assign wdog_active = busy_q && (in_collect || (back_q == B_SER));
  assign wdog_kick   = s2p_seen || reg_seen || cpi_seen || handoff;

  sched_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .active_i (wdog_active),
    .kick_i   (wdog_kick),
    .expire_o (wdog_expire)
  );

  // Sticky timeout: set by watchdog expiry, cleared by the next accepted frame request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (wdog_expire) begin
      timeout_q <= 1'b1;
    end else if (go_acc) begin
      timeout_q <= 1'b0;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Front (collect/IFFT) and back (CPI serialization) FSMs with their registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_q         <= F_IDLE;
      back_q          <= B_IDLE;
      nib_q           <= '0;
      ifft_q          <= '0;
      nsym_q          <= '0;
      sym_q           <= '0;
      s2p_start_q     <= 1'b0;
      s2p_reg_start_q <= 1'b0;
      cpi_start_q     <= 1'b0;
      cpi_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      s2p_start_q     <= 1'b0;
      s2p_reg_start_q <= 1'b0;
      cpi_start_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      if (frame_done_q) begin
        busy_q <= 1'b0;
      end
      if (wdog_expire) begin
        front_q     <= F_IDLE;
        back_q      <= B_IDLE;
        cpi_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        if (go_acc) begin
          busy_q          <= 1'b1;
          nsym_q          <= num_symbols;
          sym_q           <= '0;
          nib_q           <= '0;
          front_q         <= F_COLLECT;
          s2p_start_q     <= 1'b1;
          s2p_reg_start_q <= 1'b1;
        end
        case (front_q)
          F_COLLECT: begin
            if (S2P_done && (nib_q < NIB_MAX)) begin
              nib_q <= nib_q + 1'b1;
              // A done that completes the symbol does not fetch another nibble.
              if (!S2P_REG_done && (nib_q < NIB_LAST)) begin
                s2p_start_q <= 1'b1;
              end
            end
            if (S2P_REG_done) begin
              front_q <= F_IFFT;
              ifft_q  <= '0;
            end
          end
          F_IFFT: begin
            ifft_q <= ifft_q + 1'b1;
            if (ifft_end && !handoff) begin
              front_q <= F_READY;
            end
          end
          default: ;
        endcase
        if (handoff) begin
          cpi_start_q <= 1'b1;
          cpi_valid_q <= 1'b1;
          back_q      <= B_SER;
          sym_q       <= sym_q + 1'b1;
          if (more_syms) begin
            front_q         <= F_COLLECT;
            nib_q           <= '0;
            s2p_start_q     <= 1'b1;
            s2p_reg_start_q <= 1'b1;
          end else begin
            front_q <= F_IDLE;
          end
        end else if (cpi_seen) begin
          back_q      <= B_IDLE;
          cpi_valid_q <= 1'b0;
        end
        if (frame_end) begin
          frame_done_q <= 1'b1;
        end
      end
    end
  end

  assign S2P_start     = s2p_start_q;
  assign S2P_REG_start = s2p_reg_start_q;
  assign CPI_start     = cpi_start_q;
  assign CPIdataValid  = cpi_valid_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign sym_count     = sym_q;

endmodule

// File: doc/ofdm_symbol_scheduler.md
OFDM_SYMBOL_SCHEDULER -- requirements
Module: ofdm_symbol_scheduler

Interface
REQ-001 SHALL have parameter NSYM_W, 8, width of symbol-count fields.
REQ-002 SHALL have parameter IFFT_LAT, 2, fixed IFFT latency in clk cycles (1..15).
REQ-003 SHALL have parameter WDOG_CYCLES, 1023, max wait for any stage done before timeout.
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  frame request, sampled only when idle.
- num_symbols  in  NSYM_W  OFDM symbols per frame, latched on accepted go.
- S2P_done  in  1  one nibble delivered by serializer-to-parallel.
- S2P_REG_done  in  1  8 QAM symbols collected.
- CPI_done  in  1  CP-insert serialization finished.
- S2P_start  out  1  pulse: fetch next nibble.
- S2P_REG_start  out  1  pulse: begin collecting 8 symbols.
- CPI_start  out  1  pulse: CPI captures IFFT outputs.
- CPIdataValid  out  1  high while CPI serializes a symbol.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.
- sym_count  out  NSYM_W  symbols handed to CPI in the current frame.
- timeout  out  1  sticky stage-timeout flag.

Function
REQ-005 SHALL accept go only when busy=0 and num_symbols!=0; go with num_symbols=0 or busy=1 SHALL be ignored.
REQ-006 SHALL run two FSMs: front (F_IDLE, F_COLLECT, F_IFFT, F_READY) and back (B_IDLE, B_SER).
REQ-007 Accepted go at cycle 0 SHALL give busy=1, S2P_REG_start=1 and S2P_start=1 at cycle 1; front enters F_COLLECT.
REQ-008 In F_COLLECT, S2P_start SHALL pulse one cycle after each S2P_done while internal nibble count <8.
REQ-009 S2P_REG_done SHALL move front to F_IFFT; S2P_done in the same cycle SHALL be counted but not restart S2P.
REQ-010 F_IFFT SHALL last exactly IFFT_LAT cycles, then F_READY.
REQ-011 Handoff: in F_READY with back in B_IDLE, CPI_start SHALL pulse next cycle, back enters B_SER, sym_count increments, CPIdataValid=1 until CPI_done.
REQ-012 After handoff, front SHALL start the next symbol (REQ-007 pulses) if sym_count<num_symbols, overlapping back serialization; else F_IDLE.
REQ-013 CPI_done while front is in F_READY SHALL allow back-to-back handoff: CPI_start next cycle, CPIdataValid stays high.
REQ-014 CPI_done for the last symbol SHALL give frame_done=1 and busy=1 next cycle, busy=0 the cycle after.
REQ-015 done inputs arriving in states not awaiting them SHALL be ignored.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 rst SHALL immediately force both FSMs idle, counters 0, all outputs 0, including mid-frame.
REQ-018 First go SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-019 With SCHED_WATCHDOG_EN defined, a counter SHALL restart on each awaited-done wait; reaching WDOG_CYCLES SHALL set timeout, force idle, drop busy without frame_done; timeout clears on next accepted go.
REQ-020 Without SCHED_WATCHDOG_EN, timeout SHALL be constant 0 and no watchdog logic SHALL exist.

Structure
REQ-021 Package ofdm_sched_pkg SHALL hold front/back state enums and NIBBLES_PER_SYM=8.
REQ-022 The watchdog SHALL be sub-module sched_watchdog, instantiated only under SCHED_WATCHDOG_EN.

Verification
REQ-023 num_symbols=1, S2P_done every 4 cycles, S2P_REG_done with 8th -> 8 S2P_start pulses, one CPI_start IFFT_LAT+1 cycles after S2P_REG_done, one frame_done, sym_count=1.
REQ-024 num_symbols=3, CPI_done 40 cycles after CPI_start -> second collection overlaps B_SER, 3 CPI_start pulses, CPIdataValid contiguous, sym_count=3.
REQ-025 go with num_symbols=0, and go while busy -> ignored, no output change.
REQ-026 rst asserted mid-B_SER of symbol 2 of 4 -> all outputs 0 immediately; next go starts a clean frame.
REQ-027 SCHED_WATCHDOG_EN, WDOG_CYCLES=16, CPI_done withheld -> timeout=1 at 16 cycles, busy=0, no frame_done; next go clears timeout.
